fixed_point_divider: RTL and testbench
======================================

// Module: fixed_point_divider
// PURPOSE
//  Sequential signed fixed-point divider, Result = A / B, the inverse of the
//  filter datapath's saturating fixed-point multiplier. Same operand format
//  (two's complement, N bits, Q fraction bits; default Q8.8).
//  Used for coefficient normalisation and gain computation off the per-sample
//  critical path. Radix-2 restoring divider, one quotient bit per clock, start/done handshake.
// PARAMETERS
//  N  16  operand/result width, two's complement
//  Q  8   fraction bits in A, B and Result (0 <= Q < N)
// PORTS
//  clk          in   1  single clock, rising edge
//  rst          in   1  asynchronous reset, active-low
//  start        in   1  request; sampled only in IDLE
//  A            in   N  dividend, QN-Q.Q
//  B            in   N  divisor, QN-Q.Q
//  busy         out  1  high from the edge that accepts start until done falls
//  done         out  1  one-cycle pulse: Result/div_by_zero valid
//  Result       out  N  quotient, QN-Q.Q, saturated; held until next done
//  div_by_zero  out  1  B==0 on the accepted request; held with Result
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; busy=0, done=0, Result=0, div_by_zero=0.
//  - FSM states and transitions:
//    IDLE -> CALC on start=1: latch A and B, sign=A[N-1]^B[N-1],
//      |A| and |B| as N-bit unsigned (|-2^(N-1)| = 2^(N-1) fits),
//      numerator = |A|<<Q (N+Q bits), remainder=0, count=N+Q-1.
//    CALC: one restoring step per edge (shift in the next numerator MSB,
//      trial-subtract |B|, set the quotient bit when non-negative).
//      count==0 -> DONE.
//    DONE: registers Result/div_by_zero; done=1 for exactly this cycle -> IDLE.
//  - Latency: start sampled at edge 0 -> done=1 after edge N+Q+1 (25 clk default).
//    Back-to-back: next start is accepted in the IDLE cycle after done.
//  - start while busy: ignored, and no effect on the operation in flight.
//    A and B may change freely after acceptance.
//  - Rounding: magnitude truncated (rounds toward zero); the sign is applied last.
//  - Saturation: positive quotient > 2^(N-1)-1 -> 2^(N-1)-1 (0x7FFF).
//    Negative quotient with magnitude > 2^(N-1) -> -2^(N-1) (0x8000).
//    The N+Q-bit internal quotient is compared before sign application.
//  - Zero result is never negative zero: sign is ignored when magnitude==0.
//  - B==0: the FSM still runs the full latency (fixed timing) and div_by_zero=1.
//    A>=0 -> Result=0x7FFF; A<0 -> Result=0x8000.
//  - Reset mid-operation: abort at once, go to IDLE with reset values; no done.
// TESTING
//  1 A=0x04E0 (4.875), B=0x0340 (3.25), start -> 25 clk later done=1,
//    Result=0x0180, div_by_zero=0.
//  2 A=0xFB20 (-4.875), B=0x0340 -> Result=0xFE80 (-1.5).
//    A=0xFB20, B=0xFCC0 -> Result=0x0180.
//  3 Truncation: A=0x0100, B=0x0300 -> 0x0055; A=0xFF00, B=0x0300 -> 0xFFAB.
//  4 Saturation: A=0x7F80, B=0x0080 -> 0x7FFF.
//    A=0x8000, B=0x0080 -> 0x8000.
//    A=0x8000, B=0xFF00 (-1) -> 0x7FFF.
//  5 Divide-by-zero: A=0x0100, B=0 -> 0x7FFF, div_by_zero=1.
//    A=0xFF00, B=0 -> 0x8000, div_by_zero=1.
//  6 Control: pulse start again at cycle 5 -> ignored, single done at 25.
//    Drop rst at cycle 10 -> busy=0, Result=0, no done.
//    New request after release -> correct result.

Source files
------------

// File: rtl/fixed_point_divider.sv
// fixed_point_divider: sequential signed fixed-point divider, radix-2 restoring,
// one quotient bit per clock, saturating result with start/done handshake.
module fixed_point_divider #(
   parameter int N = 16,
   parameter int Q = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] Result,
   output logic         div_by_zero
);
   localparam int W  = N + Q;
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [W-1:0] POS_LIM = W'((64'd1 << (N - 1)) - 64'd1);
   localparam logic [W-1:0] NEG_LIM = W'(64'd1 << (N - 1));
   localparam logic [N-1:0] MAX_POS = {1'b0, {(N - 1){1'b1}}};
   localparam logic [N-1:0] MIN_NEG = {1'b1, {(N - 1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  num_q, num_d;
   logic [N-1:0]  rem_q, rem_d;
   logic [N-1:0]  div_q, div_d;
   logic          sign_q, sign_d;
   logic          zero_q, zero_d;
   logic [N-1:0]  result_q, result_d;
   logic          dbz_q, dbz_d;
   logic          done_q, done_d;

   logic [N-1:0]  abs_a, abs_b;
   logic [N:0]    rem_sh;
   logic          ge;
   logic [N-1:0]  sat_res;

   assign abs_a  = A[N-1] ? -A : A;
   assign abs_b  = B[N-1] ? -B : B;
   // num_q doubles as the quotient: numerator bits shift out the top while
   // quotient bits shift in at the bottom
   assign rem_sh = {rem_q, num_q[W-1]};
   assign ge     = rem_sh >= {1'b0, div_q};
   assign sat_res = zero_q ? (sign_q ? MIN_NEG : MAX_POS)
                  : sign_q ? (num_q > NEG_LIM ? MIN_NEG : -num_q[N-1:0])
                  : (num_q > POS_LIM ? MAX_POS : num_q[N-1:0]);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      num_d    = num_q;
      rem_d    = rem_q;
      div_d    = div_q;
      sign_d   = sign_q;
      zero_d   = zero_q;
      result_d = result_q;
      dbz_d    = dbz_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !done_q) begin
               state_d = CALC;
               cnt_d   = CW'(W - 1);
               num_d   = W'(abs_a) << Q;
               rem_d   = '0;
               div_d   = abs_b;
               sign_d  = A[N-1] ^ B[N-1];
               zero_d  = (B == '0);
            end
         end
         CALC: begin
            num_d = {num_q[W-2:0], ge};
            rem_d = ge ? rem_sh[N-1:0] - div_q : rem_sh[N-1:0];
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) state_d = DONE;
         end
         DONE: begin
            result_d = sat_res;
            dbz_d    = zero_q;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         num_q    <= '0;
         rem_q    <= '0;
         div_q    <= '0;
         sign_q   <= 1'b0;
         zero_q   <= 1'b0;
         result_q <= '0;
         dbz_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         num_q    <= num_d;
         rem_q    <= rem_d;
         div_q    <= div_d;
         sign_q   <= sign_d;
         zero_q   <= zero_d;
         result_q <= result_d;
         dbz_q    <= dbz_d;
         done_q   <= done_d;
      end
   end

   assign busy        = (state_q != IDLE) || done_q;
   assign done        = done_q;
   assign Result      = result_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fixed_point_divider.sv
// tb_fixed_point_divider: directed vectors against an arithmetic reference model
// with latency countdown, plus literal expectations per vector.
module tb_fixed_point_divider;
   localparam int N   = 16;
   localparam int Q   = 8;
   localparam int LAT = N + Q + 1;

   logic         clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic [N-1:0] A = '0, B = '0;
   logic         busy, done, div_by_zero;
   logic [N-1:0] Result;

   fixed_point_divider #(.N(N), .Q(Q)) dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
      .busy(busy), .done(done), .Result(Result), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;
   bit chk_en = 1'b0;

   task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [N:0] ref_div(input logic [N-1:0] a, input logic [N-1:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint q;
      logic [N-1:0] r;
      if (sb == 0) return {1'b1, a[N-1] ? 16'h8000 : 16'h7FFF};
      q = (sa * (longint'(1) << Q)) / sb;
      if (q > 32767) q = 32767;
      else if (q < -32768) q = -32768;
      r = q[N-1:0];
      return {1'b0, r};
   endfunction

   int           m_cnt = 0;
   logic         m_done = 1'b0, m_dbz = 1'b0, p_dbz = 1'b0;
   logic [N-1:0] m_res = '0, p_res = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_cnt = 0; m_done = 1'b0; m_res = '0; m_dbz = 1'b0;
      end else if (m_cnt > 0) begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_done = 1'b1;
            m_res  = p_res;
            m_dbz  = p_dbz;
         end
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (start) begin
         m_cnt = LAT;
         {p_dbz, p_res} = ref_div(A, B);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", N'(busy), N'(m_cnt > 0 || m_done));
         check("done", N'(done), N'(m_done));
         check("result", Result, m_res);
         check("dbz", N'(div_by_zero), N'(m_dbz));
      end
   end

   task automatic wait_done(input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < LAT + 10; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!seen) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s timeout: done=0 want 1", nm);
      end
   endtask

   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] er, input logic ez);
      @(negedge clk);
      A = a; B = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0; A = N'($urandom); B = N'($urandom);
      wait_done("op_done");
      check("lit_result", Result, er);
      check("lit_dbz", N'(div_by_zero), N'(ez));
   endtask

   typedef struct {
      logic [N-1:0] a, b, r;
      logic         z;
   } vec_t;

   vec_t vecs [15] = '{
      '{16'h04E0, 16'h0340, 16'h0180, 1'b0},
      '{16'hFB20, 16'h0340, 16'hFE80, 1'b0},
      '{16'hFB20, 16'hFCC0, 16'h0180, 1'b0},
      '{16'h0100, 16'h0300, 16'h0055, 1'b0},
      '{16'hFF00, 16'h0300, 16'hFFAB, 1'b0},
      '{16'h7F80, 16'h0080, 16'h7FFF, 1'b0},
      '{16'h8000, 16'h0080, 16'h8000, 1'b0},
      '{16'h8000, 16'hFF00, 16'h7FFF, 1'b0},
      '{16'h0100, 16'h0000, 16'h7FFF, 1'b1},
      '{16'hFF00, 16'h0000, 16'h8000, 1'b1},
      '{16'h0000, 16'h0340, 16'h0000, 1'b0},
      '{16'h0000, 16'h0000, 16'h7FFF, 1'b1},
      '{16'h0001, 16'hFFFF, 16'hFF00, 1'b0},
      '{16'h8000, 16'h0100, 16'h8000, 1'b0},
      '{16'h7FFF, 16'h0100, 16'h7FFF, 1'b0}
   };

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_result", Result, 16'h0000);
      check("rst_busy", N'(busy), N'(0));
      check("rst_done", N'(done), N'(0));
      check("rst_dbz", N'(div_by_zero), N'(0));
      rst = 1'b1;
      chk_en = 1'b1;
      foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].z);
      // second start mid-flight must not disturb the running divide
      @(negedge clk);
      A = 16'h04E0; B = 16'h0340; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      A = 16'h0100; B = 16'h0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("ctl_done");
      check("ctl_result", Result, 16'h0180);
      check("ctl_dbz", N'(div_by_zero), N'(0));
      // asynchronous reset in the middle of a divide
      @(negedge clk);
      A = 16'hFF00; B = 16'h0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("abort_busy", N'(busy), N'(0));
      check("abort_result", Result, 16'h0000);
      check("abort_done", N'(done), N'(0));
      check("abort_dbz", N'(div_by_zero), N'(0));
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      repeat (30) @(negedge clk);
      run_op(16'hFB20, 16'h0340, 16'hFE80, 1'b0);
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
